// File: rtl/scan_host_bridge.sv
// -----------------------------------------------------------------------------
// scan_host_bridge
//
// Transaction front end for the scan chain controller. A host request
// (design select + input byte) is latched onto the controller drive
// (active_select / inputs). The bridge then counts controller ready pulses
// until the sampled outputs are known to reflect the new drive, captures
// them and presents them on a valid/ready response channel. A watchdog
// produces a flagged response if the controller stalls.
//
// Parameters:
//   SELECT_W        width of the design select
//   IO_W            width of the input/output byte
//   SETTLE_READIES  ready pulses to count before capturing outputs (1..15)
//   TIMEOUT_CYCLES  cycles allowed in SETTLE before a timeout response (>=2)
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   req_valid/req_ready/req_select/req_inputs   host request channel
//   rsp_valid/rsp_ready/rsp_outputs/rsp_timeout host response channel
//   active_select, inputs   drive to the controller
//   outputs, ctrl_ready     from the controller (outputs valid with ready)
// -----------------------------------------------------------------------------
module scan_host_bridge #(
    parameter int SELECT_W       = 9,
    parameter int IO_W           = 8,
    parameter int SETTLE_READIES = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [SELECT_W-1:0] req_select,
    input  logic [IO_W-1:0]     req_inputs,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IO_W-1:0]     rsp_outputs,
    output logic                rsp_timeout,
    output logic [SELECT_W-1:0] active_select,
    output logic [IO_W-1:0]     inputs,
    input  logic [IO_W-1:0]     outputs,
    input  logic                ctrl_ready
);

    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE_READIES);
    localparam logic [WD_W-1:0] WD_LAST     = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state;
    logic [3:0]      pulse_cnt;
    logic [WD_W-1:0] watchdog;

    // The only combinational output: derived from state, never from req_*.
    assign req_ready = (state == IDLE) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            active_select <= '0;
            inputs        <= '0;
            rsp_valid     <= 1'b0;
            rsp_outputs   <= '0;
            rsp_timeout   <= 1'b0;
            pulse_cnt     <= '0;
            watchdog      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        active_select <= req_select;
                        inputs        <= req_inputs;
                        pulse_cnt     <= '0;
                        watchdog      <= '0;
                        state         <= SETTLE;
                    end
                end

                SETTLE: begin
                    // A settled capture takes priority over a watchdog
                    // expiry landing in the same cycle.
                    if (ctrl_ready && (pulse_cnt + 4'd1 == SETTLE_LAST)) begin
                        rsp_outputs <= outputs;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else if (watchdog == WD_LAST) begin
                        rsp_outputs <= outputs;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        // Counters only advance while staying in SETTLE,
                        // so neither can step past its terminal value.
                        watchdog <= watchdog + WD_W'(1);
                        if (ctrl_ready) begin
                            pulse_cnt <= pulse_cnt + 4'd1;
                        end
                    end
                end

                RESP: begin
                    // Response held stable; ctrl_ready is ignored here.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_host_bridge.sv
module tb_scan_host_bridge;

    localparam int SW = 9;
    localparam int IW = 8;
    localparam int SR = 2;
    localparam int TO = 48;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [SW-1:0] req_select;
    logic [IW-1:0] req_inputs;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [IW-1:0] rsp_outputs;
    logic          rsp_timeout;
    logic [SW-1:0] active_select;
    logic [IW-1:0] inputs;
    logic [IW-1:0] outputs;
    logic          ctrl_ready;

    int n_checks = 0;
    int n_fail   = 0;

    scan_host_bridge #(
        .SELECT_W      (SW),
        .IO_W          (IW),
        .SETTLE_READIES(SR),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_select   (req_select),
        .req_inputs   (req_inputs),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_outputs  (rsp_outputs),
        .rsp_timeout  (rsp_timeout),
        .active_select(active_select),
        .inputs       (inputs),
        .outputs      (outputs),
        .ctrl_ready   (ctrl_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Behavioural reference: a transaction is either absent, waiting for
    // enough ready pulses (or the watchdog), or holding a response.
    // Compared on each falling edge, then advanced with the inputs that
    // the next rising edge will sample.
    // ------------------------------------------------------------------
    logic          m_busy   = 1'b0;
    logic          m_rv     = 1'b0;
    logic [SW-1:0] m_sel    = '0;
    logic [IW-1:0] m_in     = '0;
    logic [IW-1:0] m_out    = '0;
    logic          m_to     = 1'b0;
    int            m_pulses = 0;
    int            m_waited = 0;

    initial begin
        forever begin
            @(negedge clk);
            check("req_ready",     req_ready,     !reset && !m_busy && !m_rv);
            check("active_select", active_select, m_sel);
            check("inputs",        inputs,        m_in);
            check("rsp_valid",     rsp_valid,     m_rv);
            check("rsp_outputs",   rsp_outputs,   m_out);
            check("rsp_timeout",   rsp_timeout,   m_to);

            if (reset) begin
                m_busy = 1'b0; m_rv = 1'b0; m_sel = '0; m_in = '0;
                m_out = '0; m_to = 1'b0; m_pulses = 0; m_waited = 0;
            end else if (m_rv) begin
                if (rsp_ready) m_rv = 1'b0;
            end else if (m_busy) begin
                if (ctrl_ready && (m_pulses + 1 == SR)) begin
                    m_out = outputs; m_to = 1'b0; m_rv = 1'b1; m_busy = 1'b0;
                end else if (m_waited == TO - 1) begin
                    m_out = outputs; m_to = 1'b1; m_rv = 1'b1; m_busy = 1'b0;
                end else begin
                    m_waited++;
                    if (ctrl_ready) m_pulses++;
                end
            end else if (req_valid) begin
                m_sel = req_select; m_in = req_inputs;
                m_busy = 1'b1; m_pulses = 0; m_waited = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
        $fatal(1, "bench time limit");
    end

    // Runs one request with a pulse every 4 cycles, checks the literal
    // response and completes the handshake.
    task automatic simple_txn(input logic [SW-1:0] sel, input logic [IW-1:0] din,
                              input logic [IW-1:0] dout);
        int n;
        req_select = sel; req_inputs = din; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 100) begin
            ctrl_ready = (n % 4 == 3);
            outputs    = dout;
            step();
            n++;
        end
        ctrl_ready = 1'b0;
        check("simple_rsp_seen", rsp_valid, 1'b1);
        check("simple_rsp_out",  rsp_outputs, dout);
        check("simple_rsp_to",   rsp_timeout, 1'b0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        step();
    endtask

    initial begin
        int n;
        int nrsp;

        reset = 1'b1; req_valid = 1'b1; req_select = 9'd5; req_inputs = 8'hA3;
        rsp_ready = 1'b0; outputs = 8'h00; ctrl_ready = 1'b0;

        // Reset with a request held
        repeat (3) begin
            step();
            check("rst_req_ready", req_ready, 1'b0);
            check("rst_sel",       active_select, 9'd0);
            check("rst_inputs",    inputs, 8'd0);
            check("rst_rsp_valid", rsp_valid, 1'b0);
        end

        // First request; pulse in the acceptance cycle must be ignored
        reset = 1'b0; ctrl_ready = 1'b1; outputs = 8'h77;
        #1;
        check("post_rst_req_ready", req_ready, 1'b1);
        step();
        check("acc_sel",    active_select, 9'd5);
        check("acc_inputs", inputs, 8'hA3);
        req_valid = 1'b0; ctrl_ready = 1'b0;
        repeat (19) step();
        ctrl_ready = 1'b1; outputs = 8'h11;
        step();
        ctrl_ready = 1'b0;
        check("no_rsp_after_first", rsp_valid, 1'b0);
        repeat (19) step();
        ctrl_ready = 1'b1; outputs = 8'h5C;
        step();
        ctrl_ready = 1'b0;
        check("settled_valid", rsp_valid, 1'b1);
        check("settled_out",   rsp_outputs, 8'h5C);
        check("settled_to",    rsp_timeout, 1'b0);

        // Response back-pressure with noise on the controller side
        rsp_ready = 1'b0;
        repeat (10) begin
            outputs = 8'($urandom); ctrl_ready = 1'($urandom);
            req_valid = 1'b1; req_select = 9'($urandom);
            step();
            check("hold_out", rsp_outputs, 8'h5C);
            check("hold_sel", active_select, 9'd5);
        end
        req_valid = 1'b0; ctrl_ready = 1'b0; rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("idle_after_hs", req_ready, 1'b1);
        step();

        // Pure timeout
        req_select = 9'd7; req_inputs = 8'h3C; req_valid = 1'b1;
        step();
        req_valid = 1'b0; outputs = 8'h9D; ctrl_ready = 1'b0;
        n = 0;
        while (!rsp_valid && n < 200) begin
            step();
            n++;
        end
        check("to_latency", n, TO);
        check("to_flag",    rsp_timeout, 1'b1);
        check("to_out",     rsp_outputs, 8'h9D);
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0; step();

        // Second pulse lands in the timeout cycle: settled wins
        req_select = 9'd8; req_inputs = 8'h01; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int k = 0; k < TO; k++) begin
            ctrl_ready = (k == 5) || (k == TO - 1);
            outputs    = (k == TO - 1) ? 8'h42 : 8'h21;
            step();
        end
        ctrl_ready = 1'b0;
        check("tie_valid", rsp_valid, 1'b1);
        check("tie_to",    rsp_timeout, 1'b0);
        check("tie_out",   rsp_outputs, 8'h42);
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0; step();

        // Reset during SETTLE
        req_select = 9'd3; req_inputs = 8'h44; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        check("rs_sel",   active_select, 9'd0);
        check("rs_in",    inputs, 8'd0);
        check("rs_valid", rsp_valid, 1'b0);
        reset = 1'b0;
        step();

        // Reset during RESP
        req_select = 9'd4; req_inputs = 8'h55; req_valid = 1'b1;
        step();
        req_valid = 1'b0; ctrl_ready = 1'b1; outputs = 8'hE7;
        step(); step();
        ctrl_ready = 1'b0;
        check("rr_valid_before", rsp_valid, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        check("rr_valid_after", rsp_valid, 1'b0);
        check("rr_out_after",   rsp_outputs, 8'h00);
        check("rr_to_after",    rsp_timeout, 1'b0);
        simple_txn(9'd6, 8'h66, 8'hB4);

        // Back-to-back requests with rsp_ready tied high
        nrsp = 0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (nrsp == 2) break;
            outputs    = 8'(active_select) + 8'd1;
            ctrl_ready = (k % 3 == 0);
            req_valid  = 1'b1;
            req_select = (nrsp == 0) ? 9'd0 : 9'd99;
            req_inputs = 8'h0F;
            step();
            if (rsp_valid) begin
                check("b2b_out", rsp_outputs, (nrsp == 0) ? 8'd1 : 8'd100);
                check("b2b_to",  rsp_timeout, 1'b0);
                nrsp++;
            end
        end
        req_valid = 1'b0; ctrl_ready = 1'b0;
        check("b2b_count", nrsp, 2);
        step();
        rsp_ready = 1'b0;
        step();

        // Randomized traffic; sparse pulses in the second half for timeouts
        for (int k = 0; k < 1200; k++) begin
            reset      = ($urandom_range(0, 199) == 0);
            req_valid  = 1'($urandom);
            req_select = 9'($urandom);
            req_inputs = 8'($urandom);
            rsp_ready  = ($urandom_range(0, 2) != 0);
            ctrl_ready = (k < 600) ? ($urandom_range(0, 3) == 0)
                                   : ($urandom_range(0, 39) == 0);
            outputs    = 8'($urandom);
            step();
        end

        reset = 1'b0; req_valid = 1'b0; ctrl_ready = 1'b0; rsp_ready = 1'b1;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
